dmem_write_buffer: RTL and testbench

DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

---
 rtl/dmem_write_buffer_pkg.sv | 15 +
 rtl/dmem_write_buffer_fwd_match.sv | 46 ++++
 rtl/dmem_write_buffer.sv | 97 +++++++++
 tb/tb_dmem_write_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_write_buffer_pkg.sv
// Shared types for the data-memory write buffer: scalar typedefs, the
// buffered-store entry layout and the default buffer depth.
package dmem_write_buffer_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef struct packed {
    u32 addr;
    u32 data;
  } wb_entry_t;

  localparam int WB_DEPTH_DEF = 4;

endpackage

// File: rtl/dmem_write_buffer_fwd_match.sv
// Store-to-load forwarding lookup: walks entries oldest to youngest from head
// so the youngest word-address match wins.
module wb_fwd_match
  import dmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  wb_entry_t                  i_entries [DEPTH],
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  u32                         i_rd_addr,
  output u1                          o_hit,
  output u32                         o_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;
  logic          w_unused_lsb;

  // Priority scan in age order; a later (younger) match overrides an earlier one
  always_comb begin
    o_hit  = 1'b0;
    o_data = 32'h0000_0000;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_valid[w_idx] && (i_entries[w_idx].addr[31:2] == i_rd_addr[31:2])) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end else begin
        o_hit  = o_hit;
        o_data = o_data;
      end
    end
  end

  // Byte-offset bits take no part in a word match
  always_comb begin
    w_unused_lsb = ^i_rd_addr[1:0];
    for (int k = 0; k < DEPTH; k++) begin
      w_unused_lsb = w_unused_lsb ^ (^i_entries[k].addr[1:0]);
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Circular write buffer between CPU stores and data memory, with optional
// store-to-load forwarding compiled in by DMEM_WB_FORWARD_EN.
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic        stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_misalign;
  wb_entry_t     r_mem [DEPTH];

  logic             w_enq;
  logic             w_deq;
  logic             w_misaligned;
  logic [DEPTH-1:0] w_valid;
  logic [PW-1:0]    w_off [DEPTH];

  assign stall        = (r_count == CW'(DEPTH));
  assign mem_we       = (r_count != '0);
  assign mem_addr     = mem_we ? r_mem[r_head].addr : 32'h0000_0000;
  assign mem_wdata    = mem_we ? r_mem[r_head].data : 32'h0000_0000;
  assign misalign_err = r_misalign;

  assign w_misaligned = memwrite && (dataaddr[1:0] != 2'b00);
  assign w_enq        = memwrite && !stall && (dataaddr[1:0] == 2'b00);
  assign w_deq        = mem_we && mem_ready;

  // Slot g is live when its distance from head is inside the occupied span
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign w_off[g]   = PW'(g) - r_head;
    assign w_valid[g] = ({1'b0, w_off[g]} < r_count);
  end

  // Pointer, occupancy and sticky-error state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_misaligned) r_misalign <= 1'b1;
    end
  end

  // Entry payload needs no reset; reads are masked by occupancy
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= '{addr: dataaddr, data: writedata};
  end

`ifdef DMEM_WB_FORWARD_EN
  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_rd_addr (rd_addr),
    .o_hit     (rd_hit),
    .o_data    (rd_data)
  );
`else
  logic w_unused_fwd;
  assign w_unused_fwd = (^rd_addr) ^ (^w_valid);
  assign rd_hit       = 1'b0;
  assign rd_data      = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed self-checking bench for dmem_write_buffer; forwarding expectations
// follow DMEM_WB_FORWARD_EN.
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic        stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_write_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .dataaddr     (dataaddr),
    .writedata    (writedata),
    .stall        (stall),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .rd_addr      (rd_addr),
    .rd_hit       (rd_hit),
    .rd_data      (rd_data),
    .misalign_err (misalign_err)
  );

`ifdef DMEM_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataaddr  = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataaddr = 32'h0; writedata = 32'h0;
    mem_ready = 1'b0; rd_addr = 32'h0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_stall", {31'h0, stall}, 32'd0);
    check("rst_mem_we", {31'h0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_misalign", {31'h0, misalign_err}, 32'd0);
    check("rst_rd_hit", {31'h0, rd_hit}, 32'd0);

    // Single store, one-cycle latency, drained on the following edge
    mem_ready = 1'b1;
    memwrite = 1'b1; dataaddr = 32'd88; writedata = 32'd30;
    #1;
    check("lat_pre_we", {31'h0, mem_we}, 32'd0);
    tick();
    memwrite = 1'b0;
    #1;
    check("lat_we", {31'h0, mem_we}, 32'd1);
    check("lat_addr", mem_addr, 32'd88);
    check("lat_data", mem_wdata, 32'd30);
    tick();
    check("lat_empty", {31'h0, mem_we}, 32'd0);

    // Fill to full, overflow store ignored, in-order drain
    mem_ready = 1'b0;
    store(32'd80, 32'd1);
    store(32'd84, 32'd2);
    store(32'd88, 32'd3);
    check("fill3_stall", {31'h0, stall}, 32'd0);
    store(32'd92, 32'd4);
    check("full_stall", {31'h0, stall}, 32'd1);
    check("full_head", mem_addr, 32'd80);
    store(32'd96, 32'd5);
    check("ovf_stall", {31'h0, stall}, 32'd1);
    check("ovf_head", mem_addr, 32'd80);
    mem_ready = 1'b1;
    #1;
    check("drain0_data", mem_wdata, 32'd1);
    tick();
    check("drain1_stall", {31'h0, stall}, 32'd0);
    check("drain1_addr", mem_addr, 32'd84);
    check("drain1_data", mem_wdata, 32'd2);
    tick();
    check("drain2_addr", mem_addr, 32'd88);
    tick();
    check("drain3_addr", mem_addr, 32'd92);
    check("drain3_data", mem_wdata, 32'd4);
    tick();
    check("drain_empty", {31'h0, mem_we}, 32'd0);

    // Full buffer: drain and store in same cycle, store accepted one cycle later
    mem_ready = 1'b0;
    store(32'h100, 32'h10);
    store(32'h104, 32'h11);
    store(32'h108, 32'h12);
    store(32'h10C, 32'h13);
    memwrite = 1'b1; dataaddr = 32'h200; writedata = 32'hAA; mem_ready = 1'b1;
    #1;
    check("fd_pre_stall", {31'h0, stall}, 32'd1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("fd_stall", {31'h0, stall}, 32'd0);
    check("fd_head", mem_addr, 32'h104);
    tick();
    memwrite = 1'b0;
    check("fd_accept_stall", {31'h0, stall}, 32'd1);
    mem_ready = 1'b1;
    tick();
    check("fd_d1", mem_addr, 32'h108);
    tick();
    check("fd_d2", mem_addr, 32'h10C);
    tick();
    check("fd_d3_addr", mem_addr, 32'h200);
    check("fd_d3_data", mem_wdata, 32'hAA);
    tick();
    check("fd_empty", {31'h0, mem_we}, 32'd0);

    // Forwarding: youngest match wins, word granularity, miss reads zero
    mem_ready = 1'b0;
    store(32'd84, 32'd5);
    store(32'd84, 32'd7);
    rd_addr = 32'd84; #1;
    check("fwd_hit", {31'h0, rd_hit}, FWD ? 32'd1 : 32'd0);
    check("fwd_data", rd_data, FWD ? 32'd7 : 32'd0);
    rd_addr = 32'd86; #1;
    check("fwd_word_hit", {31'h0, rd_hit}, FWD ? 32'd1 : 32'd0);
    check("fwd_word_data", rd_data, FWD ? 32'd7 : 32'd0);
    rd_addr = 32'd100; #1;
    check("fwd_miss_hit", {31'h0, rd_hit}, 32'd0);
    check("fwd_miss_data", rd_data, 32'd0);
    rd_addr = 32'd84;
    mem_ready = 1'b1;
    tick();
    check("fwd_deq_hit", {31'h0, rd_hit}, FWD ? 32'd1 : 32'd0);
    check("fwd_deq_data", rd_data, FWD ? 32'd7 : 32'd0);
    tick();
    check("fwd_empty_hit", {31'h0, rd_hit}, 32'd0);
    check("fwd_empty_data", rd_data, 32'd0);

    // Misaligned store is dropped and the error flag sticks
    mem_ready = 1'b0;
    store(32'd82, 32'd9);
    check("mis_we", {31'h0, mem_we}, 32'd0);
    check("mis_flag", {31'h0, misalign_err}, 32'd1);
    tick();
    check("mis_hold", {31'h0, misalign_err}, 32'd1);

    // Reset with three queued entries discards them
    store(32'h300, 32'h1);
    store(32'h304, 32'h2);
    store(32'h308, 32'h3);
    check("pre_rst_head", mem_addr, 32'h300);
    reset = 1'b1; memwrite = 1'b1; dataaddr = 32'h30C; writedata = 32'h4; mem_ready = 1'b1;
    tick();
    reset = 1'b0; memwrite = 1'b0; mem_ready = 1'b0;
    #1;
    check("mid_rst_we", {31'h0, mem_we}, 32'd0);
    check("mid_rst_stall", {31'h0, stall}, 32'd0);
    check("mid_rst_mis", {31'h0, misalign_err}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    mem_ready = 1'b1;
    tick();
    check("post_rst_we", {31'h0, mem_we}, 32'd0);
    mem_ready = 1'b0;
    store(32'h40, 32'h55);
    check("post_rst_addr", mem_addr, 32'h40);
    check("post_rst_data", mem_wdata, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
